// File: rtl/fmps_pkg.sv
// Shared constants and types for the FMPS packet collector.
// Header field defaults match the FMPS header layout produced upstream of axisMux.
package fmps_pkg;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_BAD_MAGIC = 2'd1;
  localparam logic [1:0] ST_BAD_LEN   = 2'd2;
  localparam logic [1:0] ST_DUP_INDEX = 2'd3;

  localparam int HDR_MAGIC_W   = 16;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_INDEX_W   = 5;
  localparam int HDR_INDEX_LSB = 10;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hB6CF;

  typedef enum logic [1:0] {
    S_HEADER,
    S_DATA,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/fmps_packet_collector_tracker.sv
// Per-FA-cycle bookkeeping: received-index bitmap, good-packet count,
// end-of-cycle summary latch and the once-per-cycle allReceived pulse.
module fmps_cycle_tracker #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      complete,
  input  logic [INDEX_WIDTH-1:0]    index,
  input  logic                      new_cycle,
  input  logic [INDEX_WIDTH:0]      expected_count,
  output logic                      dup,
  output logic                      summary_strobe,
  output logic [2**INDEX_WIDTH-1:0] cycle_bitmap,
  output logic [INDEX_WIDTH:0]      cycle_count,
  output logic                      all_received
);

  localparam int NUM_IDX = 2**INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] COUNT_MAX = NUM_IDX[INDEX_WIDTH:0];

  logic [NUM_IDX-1:0]   bitmap, bitmap_next;
  logic [INDEX_WIDTH:0] count, count_next;
  logic                 armed;
  logic                 accept;

  assign dup    = bitmap[index];
  assign accept = complete & ~dup;

  always_comb begin
    bitmap_next = bitmap;
    count_next  = count;
    if (accept) begin
      bitmap_next[index] = 1'b1;
      if (count != COUNT_MAX) count_next = count + 1'b1;
    end
  end

  // A packet completing on the new-cycle clock belongs to the cycle that is ending.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bitmap         <= '0;
      count          <= '0;
      armed          <= 1'b1;
      summary_strobe <= 1'b0;
      cycle_bitmap   <= '0;
      cycle_count    <= '0;
      all_received   <= 1'b0;
    end else begin
      summary_strobe <= new_cycle;
      all_received   <= 1'b0;
      if (armed && (expected_count != '0) && (count == expected_count)) begin
        all_received <= 1'b1;
        armed        <= 1'b0;
      end
      if (new_cycle) begin
        cycle_bitmap <= bitmap_next;
        cycle_count  <= count_next;
        bitmap       <= '0;
        count        <= '0;
        armed        <= 1'b1;
      end else begin
        bitmap <= bitmap_next;
        count  <= count_next;
      end
    end
  end

endmodule

// File: rtl/fmps_packet_collector.sv
// Consumes the merged FMPS AXI-Stream, validates header magic and length,
// and emits one strobe per good packet plus a status pulse per packet.
//   state     | meaning
//   S_HEADER  | waiting for / checking the header beat
//   S_DATA    | collecting data words of a well-formed header
//   S_DISCARD | dropping beats of a bad packet until tlast
module fmps_packet_collector
  import fmps_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int MAGIC_WIDTH     = HDR_MAGIC_W,
  parameter int MAGIC_START_BIT = HDR_MAGIC_LSB,
  parameter int INDEX_WIDTH     = HDR_INDEX_W,
  parameter int INDEX_START_BIT = HDR_INDEX_LSB,
  parameter int NUM_DATA_WORDS  = 1
) (
  input  logic                                 clk,
  input  logic                                 arst,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic                                 s_tlast,
  input  logic [DATA_WIDTH-1:0]                s_tdata,
  input  logic [USER_WIDTH-1:0]                s_tuser,
  input  logic [MAGIC_WIDTH-1:0]               expectedHeaderMagic,
  input  logic [INDEX_WIDTH:0]                 expectedCount,
  input  logic                                 newCycleStrobe,
  output logic                                 packetStrobe,
  output logic [INDEX_WIDTH-1:0]               packetIndex,
  output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] packetData,
  output logic                                 statusStrobe,
  output logic [1:0]                           statusCode,
  output logic                                 cycleSummaryStrobe,
  output logic [2**INDEX_WIDTH-1:0]            cycleBitmap,
  output logic [INDEX_WIDTH:0]                 cycleCount,
  output logic                                 allReceived
);

  localparam int CNT_W = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam int PKT_W = DATA_WIDTH * NUM_DATA_WORDS;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);

  state_t                 state, state_next;
  logic [CNT_W-1:0]       word_cnt, word_cnt_next;
  logic [INDEX_WIDTH-1:0] index_q, index_next;
  logic [1:0]             code_q, code_next, fail_code;
  logic [PKT_W-1:0]       data_buf, data_next;
  logic                   beat, last_word, complete, fail_now, dup;
  logic                   unused_user;

  assign beat        = s_tvalid & s_tready;
  assign last_word   = (word_cnt == LAST_WORD);
  assign unused_user = ^s_tuser;

  always_comb begin
    data_next = data_buf;
    for (int w = 0; w < NUM_DATA_WORDS; w++)
      if (word_cnt == CNT_W'(w)) data_next[w*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
  end

  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    index_next    = index_q;
    code_next     = code_q;
    complete      = 1'b0;
    fail_now      = 1'b0;
    fail_code     = ST_BAD_LEN;
    if (beat) begin
      case (state)
        S_HEADER: begin
          index_next    = s_tdata[INDEX_START_BIT +: INDEX_WIDTH];
          word_cnt_next = '0;
          if (s_tlast) begin
            fail_now = 1'b1;
          end else if (s_tdata[MAGIC_START_BIT +: MAGIC_WIDTH] != expectedHeaderMagic) begin
            code_next  = ST_BAD_MAGIC;
            state_next = S_DISCARD;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (s_tlast) begin
            state_next = S_HEADER;
            if (last_word) complete = 1'b1;
            else           fail_now = 1'b1;
          end else if (last_word) begin
            code_next  = ST_BAD_LEN;
            state_next = S_DISCARD;
          end else begin
            word_cnt_next = word_cnt + 1'b1;
          end
        end
        S_DISCARD: begin
          if (s_tlast) begin
            fail_now   = 1'b1;
            fail_code  = code_q;
            state_next = S_HEADER;
          end
        end
        default: state_next = S_HEADER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= S_HEADER;
      word_cnt     <= '0;
      index_q      <= '0;
      code_q       <= ST_OK;
      data_buf     <= '0;
      s_tready     <= 1'b0;
      packetStrobe <= 1'b0;
      packetIndex  <= '0;
      packetData   <= '0;
      statusStrobe <= 1'b0;
      statusCode   <= ST_OK;
    end else begin
      s_tready     <= 1'b1;
      state        <= state_next;
      word_cnt     <= word_cnt_next;
      index_q      <= index_next;
      code_q       <= code_next;
      if (beat && state == S_DATA) data_buf <= data_next;
      packetStrobe <= complete & ~dup;
      statusStrobe <= complete | fail_now;
      if (complete)      statusCode <= dup ? ST_DUP_INDEX : ST_OK;
      else if (fail_now) statusCode <= fail_code;
      if (complete && !dup) begin
        packetIndex <= index_q;
        packetData  <= data_next;
      end
    end
  end

  fmps_cycle_tracker #(
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_tracker (
    .clk            (clk),
    .arst           (arst),
    .complete       (complete),
    .index          (index_q),
    .new_cycle      (newCycleStrobe),
    .expected_count (expectedCount),
    .dup            (dup),
    .summary_strobe (cycleSummaryStrobe),
    .cycle_bitmap   (cycleBitmap),
    .cycle_count    (cycleCount),
    .all_received   (allReceived)
  );

endmodule

// File: tb/tb_fmps_packet_collector.sv
// Bench for fmps_packet_collector with two data words per packet: a packet-level
// reference model checked every cycle plus hand-computed literal expectations.
module tb_fmps_packet_collector;
  import fmps_pkg::*;

  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [0:0]  s_tuser = '0;
  logic [15:0] expectedHeaderMagic = DEFAULT_MAGIC;
  logic [5:0]  expectedCount = 6'd4;
  logic        newCycleStrobe = 1'b0;
  logic        packetStrobe;
  logic [4:0]  packetIndex;
  logic [63:0] packetData;
  logic        statusStrobe;
  logic [1:0]  statusCode;
  logic        cycleSummaryStrobe;
  logic [31:0] cycleBitmap;
  logic [5:0]  cycleCount;
  logic        allReceived;

  fmps_packet_collector #(.NUM_DATA_WORDS(NW)) dut (
    .clk(clk), .arst(arst), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .expectedHeaderMagic(expectedHeaderMagic), .expectedCount(expectedCount),
    .newCycleStrobe(newCycleStrobe), .packetStrobe(packetStrobe),
    .packetIndex(packetIndex), .packetData(packetData),
    .statusStrobe(statusStrobe), .statusCode(statusCode),
    .cycleSummaryStrobe(cycleSummaryStrobe), .cycleBitmap(cycleBitmap),
    .cycleCount(cycleCount), .allReceived(allReceived)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: judges each packet as a whole once its tlast beat is seen.
  logic [31:0] q_pkt[$];
  bit          m_ready, m_pkt, m_stat, m_sum, m_allrx, ar_pending, fired, m_beat;
  bit   [1:0]  m_code;
  bit   [4:0]  m_index;
  bit   [63:0] m_data;
  bit   [31:0] seen, m_cbitmap;
  bit   [5:0]  m_ccount;
  int          m_cnt;
  logic [31:0] m_hdr;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      q_pkt.delete();
      m_ready = 0; m_pkt = 0; m_stat = 0; m_sum = 0; m_allrx = 0;
      ar_pending = 0; fired = 0; m_code = 0; m_index = 0; m_data = 0;
      seen = 0; m_cbitmap = 0; m_ccount = 0; m_cnt = 0;
    end else begin
      m_beat = s_tvalid && m_ready;
      m_pkt = 0; m_stat = 0; m_sum = 0;
      m_allrx = ar_pending; ar_pending = 0;
      if (m_beat) begin
        q_pkt.push_back(s_tdata);
        if (s_tlast) begin
          m_hdr  = q_pkt[0];
          m_stat = 1;
          if (q_pkt.size() == 1) m_code = ST_BAD_LEN;
          else if (m_hdr[31:16] != expectedHeaderMagic) m_code = ST_BAD_MAGIC;
          else if (q_pkt.size() != 1 + NW) m_code = ST_BAD_LEN;
          else if (seen[m_hdr[14:10]]) m_code = ST_DUP_INDEX;
          else begin
            m_code  = ST_OK;
            m_pkt   = 1;
            m_index = m_hdr[14:10];
            m_data  = {q_pkt[2], q_pkt[1]};
            seen[m_index] = 1'b1;
            m_cnt++;
            if (!fired && expectedCount != 0 && m_cnt == int'(expectedCount)) begin
              ar_pending = 1; fired = 1;
            end
          end
          q_pkt.delete();
        end
      end
      if (newCycleStrobe) begin
        m_sum = 1; m_cbitmap = seen; m_ccount = 6'(m_cnt);
        seen = 0; m_cnt = 0; fired = 0; ar_pending = 0;
      end
      m_ready = 1;
    end
  end

  int          cyc = 0, n_pkt = 0, n_allrx = 0, n_sum = 0;
  int          n_stat[4];
  int          last_pkt_cyc = 0, allrx_cyc = 0;
  logic [31:0] last_sum_bitmap = '0;
  logic [5:0]  last_sum_count = '0;

  always @(negedge clk) begin
    cyc++;
    chk("s_tready", s_tready, m_ready);
    chk("packetStrobe", packetStrobe, m_pkt);
    chk("statusStrobe", statusStrobe, m_stat);
    chk("statusCode", statusCode, m_code);
    chk("packetIndex", packetIndex, m_index);
    chk("packetData", packetData, m_data);
    chk("cycleSummaryStrobe", cycleSummaryStrobe, m_sum);
    chk("cycleBitmap", cycleBitmap, m_cbitmap);
    chk("cycleCount", cycleCount, m_ccount);
    chk("allReceived", allReceived, m_allrx);
    if (packetStrobe === 1'b1) begin n_pkt++; last_pkt_cyc = cyc; end
    if (statusStrobe === 1'b1) n_stat[statusCode]++;
    if (allReceived === 1'b1) begin n_allrx++; allrx_cyc = cyc; end
    if (cycleSummaryStrobe === 1'b1) begin
      n_sum++; last_sum_bitmap = cycleBitmap; last_sum_count = cycleCount;
    end
  end

  function automatic logic [31:0] hdr(input logic [15:0] magic, input logic [4:0] idx);
    logic [31:0] h;
    h = '0; h[31:16] = magic; h[14:10] = idx;
    return h;
  endfunction

  function automatic logic [31:0] dword(input logic [4:0] idx, input int i);
    return 32'h0103CA01 + {19'd0, idx, 8'd0} + 32'(i);
  endfunction

  task automatic beat(input logic [31:0] d, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] magic, input logic [4:0] idx, input int ndata);
    beat(hdr(magic, idx), ndata == 0);
    for (int i = 0; i < ndata; i++) beat(dword(idx, i), i == ndata - 1);
  endtask

  task automatic new_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0; newCycleStrobe = 1'b1;
    @(negedge clk);
    newCycleStrobe = 1'b0;
  endtask

  task automatic clear_counts();
    n_pkt = 0; n_allrx = 0; n_sum = 0;
    for (int i = 0; i < 4; i++) n_stat[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) n_stat[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_tready", s_tready, 1'b0);
    chk("reset_statusStrobe", statusStrobe, 1'b0);
    #2 arst = 1'b0;
    idle(2);
    chk("tready_after_reset", s_tready, 1'b1);

    // four good packets back to back, indices 0..3
    clear_counts();
    for (int k = 0; k < 4; k++) send(DEFAULT_MAGIC, 5'(k), NW);
    idle(4);
    chk("t1_pkt_count", n_pkt, 4);
    chk("t1_ok_count", n_stat[0], 4);
    chk("t1_allrx_count", n_allrx, 1);
    chk("t1_allrx_latency", allrx_cyc - last_pkt_cyc, 1);
    chk("t1_last_index", packetIndex, 5'd3);
    chk("t1_last_data", packetData, 64'h0103CD02_0103CD01);
    new_cycle();
    idle(3);
    chk("t1_sum_bitmap", last_sum_bitmap, 32'h0000000F);
    chk("t1_sum_count", last_sum_count, 6'd4);

    // bad magic, short packet, long packet, then a good one
    clear_counts();
    send(16'hDEAD, 5'd4, 1);
    send(DEFAULT_MAGIC, 5'd1, 1);
    send(DEFAULT_MAGIC, 5'd2, 3);
    send(DEFAULT_MAGIC, 5'd9, NW);
    idle(4);
    chk("t2_bad_magic", n_stat[1], 1);
    chk("t2_bad_len", n_stat[2], 2);
    chk("t2_pkt_count", n_pkt, 1);
    chk("t2_index", packetIndex, 5'd9);
    new_cycle();
    idle(3);
    chk("t2_sum_bitmap", last_sum_bitmap, 32'h00000200);
    chk("t2_sum_count", last_sum_count, 6'd1);

    // duplicate index within a cycle, accepted again after the boundary
    clear_counts();
    send(DEFAULT_MAGIC, 5'd5, NW);
    send(DEFAULT_MAGIC, 5'd5, NW);
    idle(4);
    chk("t3_dup", n_stat[3], 1);
    chk("t3_pkt_count", n_pkt, 1);
    new_cycle();
    idle(3);
    chk("t3_sum_count", last_sum_count, 6'd1);
    chk("t3_sum_bitmap", last_sum_bitmap, 32'h00000020);
    clear_counts();
    send(DEFAULT_MAGIC, 5'd5, NW);
    idle(4);
    chk("t3_reaccept", n_pkt, 1);

    // tlast of index 7 on the same clock as newCycleStrobe
    beat(hdr(DEFAULT_MAGIC, 5'd7), 1'b0);
    beat(dword(5'd7, 0), 1'b0);
    newCycleStrobe = 1'b1;
    beat(dword(5'd7, 1), 1'b1);
    newCycleStrobe = 1'b0;
    idle(4);
    chk("t4_sum_bitmap", last_sum_bitmap, 32'h000000A0);
    chk("t4_sum_count", last_sum_count, 6'd2);
    new_cycle();
    idle(3);
    chk("t4_next_count", last_sum_count, 6'd0);
    chk("t4_next_bitmap", last_sum_bitmap, 32'h0);

    // reset between header and data beats
    clear_counts();
    beat(hdr(DEFAULT_MAGIC, 5'd3), 1'b0);
    s_tvalid = 1'b0;
    #2 arst = 1'b1;
    @(negedge clk);
    chk("t5_tready_in_reset", s_tready, 1'b0);
    @(negedge clk);
    #2 arst = 1'b0;
    idle(2);
    send(DEFAULT_MAGIC, 5'd3, NW);
    idle(4);
    chk("t5_status_total", n_stat[0] + n_stat[1] + n_stat[2] + n_stat[3], 1);
    chk("t5_pkt_count", n_pkt, 1);
    new_cycle();
    idle(3);
    chk("t5_sum_bitmap", last_sum_bitmap, 32'h00000008);
    chk("t5_sum_count", last_sum_count, 6'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
